// File: rtl/iram_icb_arb_if.sv
// iram_icb_arb_if: one ICB port, command and response channels.
// master drives commands and takes responses; slave does the reverse.
interface iram_icb_arb_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_read;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );
  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/iram_icb_arb.sv
// iram_icb_arb: round-robin 2:1 ICB arbiter in front of the iram.
// One transaction in flight; the arbiter answers writes itself and times out silent reads.
module iram_icb_arb #(
  parameter int IRAM_DEPTH = 4096,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          rst,
  iram_icb_arb_if.slave  m0_icb,
  iram_icb_arb_if.slave  m1_icb,
  iram_icb_arb_if.master s_icb,
  output logic          arb_busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_RSP, TO_ERR} state_e;
  state_e        state_q;
  logic          gnt_q, rr_last_q, out_err_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          idle, win, cmd_hs, g_rsp_ready, rsp_v, rsp_e;
  logic [31:0]   rsp_d;
  always_comb begin
    idle = state_q == IDLE;
    win = (m0_icb.cmd_valid && m1_icb.cmd_valid) ? ~rr_last_q : m1_icb.cmd_valid;
    s_icb.cmd_valid = idle && !rst && (win ? m1_icb.cmd_valid : m0_icb.cmd_valid);
    s_icb.cmd_addr  = win ? m1_icb.cmd_addr  : m0_icb.cmd_addr;
    s_icb.cmd_read  = win ? m1_icb.cmd_read  : m0_icb.cmd_read;
    s_icb.cmd_wdata = win ? m1_icb.cmd_wdata : m0_icb.cmd_wdata;
    s_icb.cmd_wmask = win ? m1_icb.cmd_wmask : m0_icb.cmd_wmask;
    m0_icb.cmd_ready = idle && !rst && !win && s_icb.cmd_ready;
    m1_icb.cmd_ready = idle && !rst && win && s_icb.cmd_ready;
    cmd_hs = s_icb.cmd_valid && s_icb.cmd_ready;
    g_rsp_ready = gnt_q ? m1_icb.rsp_ready : m0_icb.rsp_ready;
    // reads pass the iram response through; writes and timeouts are answered locally
    rsp_v = state_q == RD_WAIT ? s_icb.rsp_valid : !idle;
    rsp_e = state_q == RD_WAIT ? s_icb.rsp_err
          : (state_q == TO_ERR) || (state_q == WR_RSP && out_err_q);
    rsp_d = state_q == RD_WAIT ? s_icb.rsp_rdata : 32'h0;
    s_icb.rsp_ready = state_q == RD_WAIT ? g_rsp_ready : 1'b1;
    m0_icb.rsp_valid = rsp_v && !gnt_q;
    m0_icb.rsp_err   = rsp_e && !gnt_q;
    m0_icb.rsp_rdata = gnt_q ? 32'h0 : rsp_d;
    m1_icb.rsp_valid = rsp_v && gnt_q;
    m1_icb.rsp_err   = rsp_e && gnt_q;
    m1_icb.rsp_rdata = gnt_q ? rsp_d : 32'h0;
    cnt_d = cnt_q == TO_C ? cnt_q : cnt_q + 1'b1;
    arb_busy = !idle;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      gnt_q     <= 1'b0;
      cnt_q     <= '0;
      out_err_q <= 1'b0;
    end else
      case (state_q)
        IDLE: if (cmd_hs) begin
          gnt_q     <= win;
          out_err_q <= {2'b00, s_icb.cmd_addr[31:2]} >= 32'(IRAM_DEPTH);
          cnt_q     <= '0;
          state_q   <= s_icb.cmd_read ? RD_WAIT : WR_RSP;
        end
        RD_WAIT: if (s_icb.rsp_valid) begin
          if (g_rsp_ready) begin
            state_q   <= IDLE;
            rr_last_q <= gnt_q;
          end
        end else begin
          cnt_q <= cnt_d;
          if (cnt_d == TO_C) state_q <= TO_ERR;
        end
        default: if (g_rsp_ready) begin
          state_q   <= IDLE;
          rr_last_q <= gnt_q;
        end
      endcase
endmodule

// File: doc/iram_icb_arb.md
IRAM_ICB_ARB -- requirements
Module: iram_icb_arb

Interface
REQ-001 SHALL have parameter IRAM_DEPTH, default 4096, giving the iram size in 32-bit words (error bound).
REQ-002 SHALL have parameter TIMEOUT, default 16, giving the maximum cycles to wait for a read response.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 mN_icb_cmd_valid  input  1  (N=0,1) master N command valid; m0 = core LSU, m1 = ISP/debug loader.
REQ-006 mN_icb_cmd_ready  output  1  master N command accepted.
REQ-007 mN_icb_cmd_addr  input  32  master N byte address.
REQ-008 mN_icb_cmd_read  input  1  master N read (1) or write (0).
REQ-009 mN_icb_cmd_wdata  input  32  master N write data.
REQ-010 mN_icb_cmd_wmask  input  4  master N byte write strobes.
REQ-011 mN_icb_rsp_valid  output  1  response valid to master N.
REQ-012 mN_icb_rsp_ready  input  1  master N accepts the response.
REQ-013 mN_icb_rsp_err  output  1  response error to master N.
REQ-014 mN_icb_rsp_rdata  output  32  read data to master N.
REQ-015 s_icb_cmd_valid / s_icb_cmd_addr / s_icb_cmd_read / s_icb_cmd_wdata / s_icb_cmd_wmask  output  1/32/1/32/4  command to the iram ICB slave.
REQ-016 s_icb_cmd_ready  input  1  iram accepts the command.
REQ-017 s_icb_rsp_valid / s_icb_rsp_err / s_icb_rsp_rdata  input  1/1/32  iram read response.
REQ-018 s_icb_rsp_ready  output  1  arbiter accepts the iram response.
REQ-019 arb_busy  output  1  high in any state other than IDLE.

Function
REQ-020 States SHALL be IDLE, RD_WAIT, WR_RSP and TO_ERR, with at most one outstanding transaction.
REQ-021 In IDLE, the winner SHALL be chosen combinationally: if one master is valid, it wins; if both are valid, the master that did not win last wins (rr_last).
REQ-022 In IDLE, the winner's command fields SHALL drive the s_icb_cmd_* signals with zero latency, and s_icb_cmd_valid SHALL equal the winner's cmd_valid.
REQ-023 In IDLE, winner cmd_ready SHALL equal s_icb_cmd_ready; the loser's cmd_ready SHALL be 0.
REQ-024 cmd_ready SHALL be 0 for both masters in every state other than IDLE.
REQ-025 On a command handshake, the arbiter SHALL latch gnt (the winner) and out_err = (addr[31:2] >= IRAM_DEPTH).
REQ-026 On a command handshake, the next state SHALL be RD_WAIT if the command is a read, otherwise WR_RSP.
REQ-027 RD_WAIT: mgnt_rsp_valid/err/rdata SHALL equal s_icb_rsp_*, and s_icb_rsp_ready SHALL equal mgnt_rsp_ready.
REQ-028 RD_WAIT: on the response handshake, the arbiter SHALL go to IDLE and set rr_last = gnt.
REQ-029 RD_WAIT: the timeout counter SHALL clear on entry and increment each cycle while s_icb_rsp_valid = 0.
REQ-030 RD_WAIT: when the counter reaches TIMEOUT with no response, the arbiter SHALL go to TO_ERR.
REQ-031 The timeout counter width SHALL be clog2(TIMEOUT+1) bits, and the counter SHALL saturate (never wrap).
REQ-032 WR_RSP: iram issues no write response, so the arbiter SHALL drive mgnt_rsp_valid=1, rsp_err=out_err, rdata=0 until mgnt_rsp_ready.
REQ-033 WR_RSP: on mgnt_rsp_ready, the arbiter SHALL go to IDLE and set rr_last = gnt.
REQ-034 TO_ERR: the arbiter SHALL drive mgnt_rsp_valid=1, rsp_err=1, rdata=0 until mgnt_rsp_ready, then go to IDLE and set rr_last = gnt.
REQ-035 s_icb_rsp_ready SHALL be 1 in IDLE, WR_RSP and TO_ERR, so that late or stray iram responses are drained and discarded.
REQ-036 The non-granted master SHALL always see rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-037 A response handshake and a new command SHALL never complete in the same cycle; the minimum back-to-back spacing is 2 cycles (cmd, rsp).
REQ-038 Response fields SHALL remain stable while rsp_valid=1 and rsp_ready=0.

Reset
REQ-039 While rst=1 (asynchronous): state=IDLE, rr_last=1 (m0 wins the first tie), gnt=0, counter=0, out_err=0.
REQ-040 While rst=1, all cmd_ready, rsp_valid and rsp_err outputs SHALL be 0, and arb_busy SHALL be 0.
REQ-041 Reset asserted mid-transaction SHALL abort it with no response to the master; any later iram response SHALL be drained in IDLE.

Verification
REQ-042 m0 read 0x10 alone, iram responds 1 cycle later with 0xDEADBEEF -> m0_rsp_valid=1, rdata=0xDEADBEEF, err=0; arb_busy high exactly 1 cycle.
REQ-043 m0 and m1 issue reads simultaneously and continuously, 4 transactions -> grants alternate m0,m1,m0,m1; each master sees only its own responses.
REQ-044 m1 write to addr 0x4 with wmask 4'b0011 -> s_icb_cmd_wmask=0011; m1 gets a local response (err=0) next cycle.
REQ-045 m1 write to addr IRAM_DEPTH*4 -> response err=1.
REQ-046 Read with iram silent for TIMEOUT cycles -> m0 gets err=1, rdata=0; a late iram rsp_valid is drained with no master response.
REQ-047 m0_rsp_ready held 0 for 3 cycles -> rsp fields stable for those cycles; m1_cmd_ready stays 0 until the handshake; rst pulse during RD_WAIT -> IDLE, no response issued.
